arbiter_game_ctrl: RTL
======================

Name: arbiter_game_ctrl

Overview:
Two-player reaction-game controller. It sequences the LED countdown block by holding it in reset and releasing it. After the countdown completes, it arbitrates the two player buttons: the first press wins. A press during the countdown is a foul. The block keeps saturating scores and drives result flags to LEDs.

Parameters:
CLOCK_FREQ, 12000000, system clock frequency in Hz.
TIMEOUT_COUNT, CLOCK_FREQ*3, cycles in ARMED with no valid press before a draw is declared.
LOCKOUT_COUNT, CLOCK_FREQ/2, cycles after entering RESULT during which start presses are ignored; must be <= TIMEOUT_COUNT.

Ports:
clk  input  1  system clock; single clock domain, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
start_in  input  1  start button, level; already synchronised and debounced.
btn_a_in  input  1  player A button, level; already synchronised and debounced.
btn_b_in  input  1  player B button, level; already synchronised and debounced.
cd_done_in  input  1  countdown finished (level, from countdown cd_done_out).
cd_reset_out  output  1  drives countdown reset; 1 = countdown held in reset.
winner_a_out  output  1  player A won the round.
winner_b_out  output  1  player B won the round.
foul_a_out  output  1  player A pressed during the countdown.
foul_b_out  output  1  player B pressed during the countdown.
draw_out  output  1  tie or timeout.
score_a_out  output  4  player A score.
score_b_out  output  4  player B score.
state_out  output  2  current state: IDLE=0, COUNTDOWN=1, ARMED=2, RESULT=3.

Behaviour:
- Press detection: press_x = x_in & ~x_q, where x_q is the previous-cycle sample. The x_q registers reset to 1, so an input already held high through reset does not register a press. Only presses (rising edges) act; levels are ignored.
- Reset values: state IDLE, cd_reset_out=1, all result flags 0, scores 0, shared cycle counter 0.
- All outputs are registered. A press sampled at edge k takes effect in state and outputs immediately after edge k.
- IDLE: cd_reset_out=1. press_start -> COUNTDOWN; cd_reset_out=0 on that same edge.
- COUNTDOWN: cd_reset_out=0. Events are evaluated in this priority order:
  - Both presses in the same cycle -> foul_a_out=1, foul_b_out=1, no score change, go to RESULT.
  - press_a only -> foul_a_out=1, score_b+1, go to RESULT.
  - press_b only -> foul_b_out=1, score_a+1, go to RESULT.
  - cd_done_in=1 with no press -> ARMED, counter cleared.
  - A press in the same cycle as cd_done_in counts as a foul.
- ARMED: cd_reset_out stays 0 and the counter increments each cycle.
  - press_a only -> winner_a_out=1, score_a+1.
  - press_b only -> winner_b_out=1, score_b+1.
  - Both in the same cycle -> draw_out=1, no score change.
  - Counter reaches TIMEOUT_COUNT-1 with no press -> draw_out=1.
  - A press on the timeout cycle is valid and takes precedence over the timeout.
  - Every outcome goes to RESULT.
- Entering RESULT: cd_reset_out=1 and the counter is cleared. Exactly one outcome combination is set and held for the whole RESULT period.
- RESULT: the counter counts up to LOCKOUT_COUNT-1, then saturates.
  - press_start before lockout expires is ignored.
  - press_start after lockout -> clear all result flags, go to COUNTDOWN, cd_reset_out=0.
  - Button presses in RESULT are ignored.
- Scores: 4-bit, saturating at 15 (no wrap). Scores are cleared only by reset.
- press_start outside IDLE and RESULT is ignored; a round cannot be restarted mid-countdown.
- Reset mid-round: asynchronous return to reset values; the countdown is held in reset immediately.
- Counter width: $clog2(TIMEOUT_COUNT). The counter is shared between the ARMED timeout and the RESULT lockout.
- Illegal state encodings are not applicable (4 states, 2 bits); the default branch goes to IDLE.

Test Plan:
1. Bench parameters for all scenarios: TIMEOUT_COUNT=20, LOCKOUT_COUNT=5.
2. Reset with btn_a_in held high, release reset, keep the button high -> no press registered; state_out=0, cd_reset_out=1, scores 0.
3. Start press -> state_out=1, cd_reset_out=0. Assert cd_done_in, then press A 3 cycles later -> winner_a_out=1, score_a_out=1, state_out=3, cd_reset_out=1.
4. Start, then press B before cd_done_in -> foul_b_out=1, score_a_out increments, winner flags 0. Press A and B in the same cycle during COUNTDOWN -> both fouls set, scores unchanged.
5. Reach ARMED with no press for 20 cycles -> draw_out=1 at cycle 20, scores unchanged. Press A and B in the same cycle in ARMED -> draw_out=1.
6. In RESULT, press start 2 cycles after entry -> ignored, state_out=3. Press start after 5 cycles -> flags cleared, state_out=1.
7. Run A wins 16 times -> score_a_out saturates at 15. Assert reset mid-COUNTDOWN -> immediate state_out=0, cd_reset_out=1, scores 0.

Source files
------------

// File: rtl/arbiter_game_ctrl.sv
// arbiter_game_ctrl: two-player reaction game sequencer, foul/winner arbiter and score keeper
module arbiter_game_ctrl #(
    parameter int CLOCK_FREQ    = 12000000,
    parameter int TIMEOUT_COUNT = CLOCK_FREQ * 3,
    parameter int LOCKOUT_COUNT = CLOCK_FREQ / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_in,
    input  logic       btn_a_in,
    input  logic       btn_b_in,
    input  logic       cd_done_in,
    output logic       cd_reset_out,
    output logic       winner_a_out,
    output logic       winner_b_out,
    output logic       foul_a_out,
    output logic       foul_b_out,
    output logic       draw_out,
    output logic [3:0] score_a_out,
    output logic [3:0] score_b_out,
    output logic [1:0] state_out
);
    localparam int CW = $clog2(TIMEOUT_COUNT);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_COUNT - 1);
    localparam logic [CW-1:0] LOCKOUT_LAST = CW'(LOCKOUT_COUNT - 1);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] COUNTDOWN = 2'd1;
    localparam logic [1:0] ARMED     = 2'd2;
    localparam logic [1:0] RESULT    = 2'd3;
    logic start_q, a_q, b_q;
    logic [CW-1:0] cnt;
    logic press_start, press_a, press_b;
    assign press_start = start_in & ~start_q;
    assign press_a     = btn_a_in & ~a_q;
    assign press_b     = btn_b_in & ~b_q;
    // previous-cycle samples start high so a level held through reset is not a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b1;
            a_q     <= 1'b1;
            b_q     <= 1'b1;
        end else begin
            start_q <= start_in;
            a_q     <= btn_a_in;
            b_q     <= btn_b_in;
        end
    end
    // round sequencing, arbitration, shared timeout/lockout counter and saturating scores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_out    <= IDLE;
            cd_reset_out <= 1'b1;
            winner_a_out <= 1'b0;
            winner_b_out <= 1'b0;
            foul_a_out   <= 1'b0;
            foul_b_out   <= 1'b0;
            draw_out     <= 1'b0;
            score_a_out  <= 4'd0;
            score_b_out  <= 4'd0;
            cnt          <= '0;
        end else begin
            case (state_out)
                IDLE: begin
                    cd_reset_out <= ~press_start;
                    if (press_start) state_out <= COUNTDOWN;
                end
                COUNTDOWN: begin
                    if (press_a || press_b) begin
                        foul_a_out   <= press_a;
                        foul_b_out   <= press_b;
                        if (press_a && !press_b && score_b_out != 4'hf) score_b_out <= score_b_out + 4'd1;
                        if (press_b && !press_a && score_a_out != 4'hf) score_a_out <= score_a_out + 4'd1;
                        state_out    <= RESULT;
                        cd_reset_out <= 1'b1;
                        cnt          <= '0;
                    end else if (cd_done_in) begin
                        state_out <= ARMED;
                        cnt       <= '0;
                    end
                end
                ARMED: begin
                    cnt <= cnt + 1'b1;
                    if (press_a || press_b || cnt == TIMEOUT_LAST) begin
                        winner_a_out <= press_a & ~press_b;
                        winner_b_out <= press_b & ~press_a;
                        draw_out     <= press_a == press_b;
                        if (press_a && !press_b && score_a_out != 4'hf) score_a_out <= score_a_out + 4'd1;
                        if (press_b && !press_a && score_b_out != 4'hf) score_b_out <= score_b_out + 4'd1;
                        state_out    <= RESULT;
                        cd_reset_out <= 1'b1;
                        cnt          <= '0;
                    end
                end
                RESULT: begin
                    if (press_start && cnt == LOCKOUT_LAST) begin
                        winner_a_out <= 1'b0;
                        winner_b_out <= 1'b0;
                        foul_a_out   <= 1'b0;
                        foul_b_out   <= 1'b0;
                        draw_out     <= 1'b0;
                        state_out    <= COUNTDOWN;
                        cd_reset_out <= 1'b0;
                    end else if (cnt != LOCKOUT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state_out    <= IDLE;
                    cd_reset_out <= 1'b1;
                end
            endcase
        end
    end
endmodule
